// File: rtl/tpu_host_seq_if.sv
// tpu_host_seq_if: A/B row input stream, C half-row output stream and the tpuv1 bus
interface tpu_host_seq_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             in_valid;
    logic [DATAW-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [DATAW-1:0] out_data;
    logic             out_ready;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_wdata;
    logic [DATAW-1:0] tpu_rdata;

    modport master (
        input  in_valid, in_data, out_ready, tpu_rdata,
        output in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
    );

    modport slave (
        output in_valid, in_data, out_ready, tpu_rdata,
        input  in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
    );
endinterface

// File: rtl/tpu_host_seq.sv
// tpu_host_seq: loads one A/B job into tpuv1, starts it, waits, and streams the C result back
module tpu_host_seq #(
    parameter int BITS_AB  = 8,
    parameter int BITS_C   = 16,
    parameter int DIM      = 8,
    parameter int ADDRW    = 16,
    parameter int DATAW    = 64,
    parameter int WAIT_CYC = 3*DIM+2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear_c,
    output logic busy,
    output logic done,
    tpu_host_seq_if.master bus
);
    localparam int CW = $clog2(2*DIM)+1;
    localparam int WW = $clog2(WAIT_CYC+1);
    localparam logic [ADDRW-1:0] A_BASE  = ADDRW'('h100);
    localparam logic [ADDRW-1:0] B_BASE  = ADDRW'('h200);
    localparam logic [ADDRW-1:0] C_BASE  = ADDRW'('h300);
    localparam logic [ADDRW-1:0] GO_ADDR = ADDRW'('h400);

    if (DATAW != DIM*BITS_AB || DATAW != (DIM/2)*BITS_C) begin : g_bad_width
        $error("tpu_host_seq: DATAW must equal DIM*BITS_AB and (DIM/2)*BITS_C");
    end

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CLR_C, START, WAIT, READ_C, FIN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx, ocnt, ocnt_nx;
    logic [WW-1:0]    wcnt, wcnt_nx;
    logic             clr, clr_nx;
    logic             r_w_nx, rd, rd_nx;
    logic [ADDRW-1:0] addr_nx;
    logic [DATAW-1:0] wdata_nx, skid;
    logic             skid_v, load, hs_in, hs_out, free;

    assign load         = state == LOAD_A || state == LOAD_B;
    assign bus.in_ready = load && !bus.tpu_r_w && cnt < CW'(DIM);
    assign hs_in        = bus.in_valid && bus.in_ready;
    assign hs_out       = bus.out_valid && bus.out_ready;
    assign free         = !bus.out_valid || bus.out_ready;
    assign busy         = state != IDLE;
    assign done         = state == FIN;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ocnt_nx  = ocnt;
        wcnt_nx  = wcnt;
        clr_nx   = clr;
        r_w_nx   = 1'b0;
        rd_nx    = 1'b0;
        addr_nx  = '0;
        wdata_nx = '0;
        case (state)
            IDLE: if (start) begin
                state_nx = LOAD_A;
                clr_nx   = clear_c;
                cnt_nx   = '0;
                ocnt_nx  = '0;
            end
            LOAD_A, LOAD_B: if (hs_in) begin
                r_w_nx   = 1'b1;
                addr_nx  = (state == LOAD_A ? A_BASE : B_BASE) | (ADDRW'(cnt) << 3);
                wdata_nx = bus.in_data;
                cnt_nx   = cnt + 1'b1;
            end else if (cnt == CW'(DIM)) begin
                // the last row write is on the bus now and retires at this edge
                cnt_nx   = '0;
                state_nx = state == LOAD_A ? LOAD_B : clr ? CLR_C : START;
            end
            CLR_C: begin
                r_w_nx   = 1'b1;
                addr_nx  = C_BASE | (ADDRW'(cnt) << 3);
                cnt_nx   = cnt == CW'(2*DIM-1) ? '0 : cnt + 1'b1;
                state_nx = cnt == CW'(2*DIM-1) ? START : CLR_C;
            end
            START: begin
                r_w_nx   = 1'b1;
                addr_nx  = GO_ADDR;
                cnt_nx   = '0;
                wcnt_nx  = WW'(WAIT_CYC-1);
                state_nx = WAIT;
            end
            WAIT: begin
                wcnt_nx  = wcnt == '0 ? wcnt : wcnt - 1'b1;
                state_nx = wcnt == '0 ? READ_C : WAIT;
            end
            READ_C: begin
                // issue only if the word landing next cycle has a free slot (out_data or skid)
                if (cnt < CW'(2*DIM) && !skid_v && free) begin
                    rd_nx   = 1'b1;
                    addr_nx = C_BASE | (ADDRW'(cnt) << 3);
                    cnt_nx  = cnt + 1'b1;
                end
                if (hs_out) begin
                    ocnt_nx  = ocnt + 1'b1;
                    state_nx = ocnt == CW'(2*DIM-1) ? FIN : READ_C;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            ocnt          <= '0;
            wcnt          <= '0;
            clr           <= 1'b0;
            rd            <= 1'b0;
            skid          <= '0;
            skid_v        <= 1'b0;
            bus.tpu_r_w   <= 1'b0;
            bus.tpu_addr  <= '0;
            bus.tpu_wdata <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            ocnt          <= ocnt_nx;
            wcnt          <= wcnt_nx;
            clr           <= clr_nx;
            rd            <= rd_nx;
            bus.tpu_r_w   <= r_w_nx;
            bus.tpu_addr  <= addr_nx;
            bus.tpu_wdata <= wdata_nx;
            if (free) begin
                bus.out_valid <= skid_v || rd;
                bus.out_data  <= skid_v ? skid : rd ? bus.tpu_rdata : bus.out_data;
            end
            if (rd && (skid_v || !free))
                skid <= bus.tpu_rdata;
            skid_v <= free ? skid_v && rd : skid_v || rd;
        end
    end
endmodule

// File: tb/tb_tpu_host_seq.sv
// tb_tpu_host_seq: job table plus reset and backpressure sequences against a tpuv1 memory model
module tb_tpu_host_seq;
    localparam int BITS_AB  = 8;
    localparam int BITS_C   = 16;
    localparam int DIM      = 8;
    localparam int ADDRW    = 16;
    localparam int DATAW    = 64;
    localparam int WAIT_CYC = 3*DIM+2;
    localparam int NW       = 2*DIM;

    typedef struct {
        logic             rw;
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] data;
        int               cyc;
    } txn_t;

    typedef struct {
        bit clr;
        int pat;
        int vprob;
        int rprob;
        bit spur;
        bit stall;
        int exp_txn;
    } job_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic clear_c = 1'b0;
    logic busy, done;

    tpu_host_seq_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus();

    tpu_host_seq #(
        .BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM),
        .ADDRW(ADDRW), .DATAW(DATAW), .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear_c(clear_c),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int rprob_g = 100;
    int stall_at = -1;
    int stall_left = 0;
    int mr, cr, ch;
    logic prev_hs_in = 1'b0;
    logic prev_stall = 1'b0;
    logic [DATAW-1:0] prev_data = '0;

    // tpuv1 memories and the bench's own expectation of C
    logic [BITS_AB-1:0] ma [DIM][DIM] = '{default: '0};
    logic [BITS_AB-1:0] mb [DIM][DIM] = '{default: '0};
    logic [BITS_C-1:0]  mc [DIM][DIM] = '{default: '0};
    logic [BITS_C-1:0]  exp_c [DIM][DIM] = '{default: '0};
    logic [DATAW-1:0]   words [NW];
    txn_t               mon_q[$];
    txn_t               exp_q[$];
    logic [DATAW-1:0]   out_q[$];
    job_t               tbl [6];

    task automatic check(input string name, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    always_comb begin
        bus.tpu_rdata = '0;
        for (int j = 0; j < DIM/2; j++)
            bus.tpu_rdata[j*BITS_C +: BITS_C] = mc[int'(bus.tpu_addr[15:4]) % DIM][int'(bus.tpu_addr[3])*(DIM/2) + j];
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tpu_r_w || bus.tpu_addr != '0)
                mon_q.push_back('{bus.tpu_r_w, bus.tpu_addr, bus.tpu_wdata, cyc});
            mr = int'(bus.tpu_addr[15:3]) % DIM;
            cr = int'(bus.tpu_addr[15:4]) % DIM;
            ch = int'(bus.tpu_addr[3]);
            if (bus.tpu_r_w) begin
                case (bus.tpu_addr[11:8])
                    4'h1: for (int k = 0; k < DIM; k++) ma[mr][k] = bus.tpu_wdata[k*BITS_AB +: BITS_AB];
                    4'h2: for (int k = 0; k < DIM; k++) mb[mr][k] = bus.tpu_wdata[k*BITS_AB +: BITS_AB];
                    4'h3: for (int j = 0; j < DIM/2; j++) mc[cr][ch*(DIM/2)+j] = bus.tpu_wdata[j*BITS_C +: BITS_C];
                    4'h4: for (int r = 0; r < DIM; r++)
                        for (int c = 0; c < DIM; c++) begin
                            int acc;
                            acc = int'($signed(mc[r][c]));
                            for (int k = 0; k < DIM; k++)
                                acc += int'($signed(ma[r][k])) * int'($signed(mb[k][c]));
                            mc[r][c] = BITS_C'(acc);
                        end
                    default: ;
                endcase
            end
            if (prev_hs_in)
                check("in_ready_after_handshake", 64'(bus.in_ready), 64'(0));
            if (prev_stall) begin
                check("stall_valid_held", 64'(bus.out_valid), 64'(1));
                check("stall_data_held", bus.out_data, prev_data);
                check("stall_no_read", 64'(!bus.tpu_r_w && bus.tpu_addr != '0), 64'(0));
            end
            if (bus.out_valid && bus.out_ready)
                out_q.push_back(bus.out_data);
            if (done)
                done_cnt++;
            prev_hs_in = bus.in_valid && bus.in_ready;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end else begin
            prev_hs_in = 1'b0;
            prev_stall = 1'b0;
        end
    end

    // downstream sink: random ready, or a forced stall once stall_at words were taken
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_at >= 0 && out_q.size() == stall_at && bus.out_valid && stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
        end else
            bus.out_ready = $urandom_range(99) < rprob_g;
    end

    function automatic logic [DATAW-1:0] exp_word(input int i);
        logic [DATAW-1:0] w;
        w = '0;
        for (int j = 0; j < DIM/2; j++)
            w[j*BITS_C +: BITS_C] = exp_c[i/2][(i%2)*(DIM/2)+j];
        return w;
    endfunction

    function automatic bit seen(input bit want_read);
        foreach (mon_q[i])
            if (want_read ? (!mon_q[i].rw && mon_q[i].addr[11:8] == 4'h3) : (mon_q[i].rw && mon_q[i].addr == 16'h400))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic make_words(input int pat);
        for (int r = 0; r < DIM; r++) begin
            words[r] = '0;
            words[DIM+r] = '0;
            for (int k = 0; k < DIM; k++) begin
                words[r][k*BITS_AB +: BITS_AB]     = pat == 0 ? BITS_AB'(r == k) : BITS_AB'($urandom);
                words[DIM+r][k*BITS_AB +: BITS_AB] = pat == 0 ? BITS_AB'(r+1) : BITS_AB'($urandom);
            end
        end
    endtask

    task automatic feed(input int n, input int vprob);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 4000) begin
            @(posedge clk);
            #1;
            bus.in_valid = $urandom_range(99) < vprob;
            bus.in_data  = words[i];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready)
                i++;
            guard++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("feed_complete", 64'(i), 64'(n));
    endtask

    task automatic pulse_start(input logic clr);
        @(posedge clk);
        #1;
        start = 1'b1;
        clear_c = clr;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear_c = 1'b0;
    endtask

    task automatic spurious();
        int g = 0;
        while (!seen(1'b0) && g < 3000) begin @(negedge clk); g++; end
        repeat (5) @(posedge clk);
        pulse_start(1'b1);
        g = 0;
        while (!seen(1'b1) && g < 3000) begin @(negedge clk); g++; end
        pulse_start(1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_out_data"}, bus.out_data, 64'(0));
        check({tag, "_tpu_r_w"}, 64'(bus.tpu_r_w), 64'(0));
        check({tag, "_tpu_addr"}, 64'(bus.tpu_addr), 64'(0));
        check({tag, "_tpu_wdata"}, bus.tpu_wdata, 64'(0));
    endtask

    task automatic run_job(input job_t j);
        int g = 0;
        int si;
        make_words(j.pat);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                int s;
                s = j.clr ? 0 : int'($signed(exp_c[r][c]));
                for (int k = 0; k < DIM; k++)
                    s += int'($signed(words[r][k*BITS_AB +: BITS_AB])) * int'($signed(words[DIM+k][c*BITS_AB +: BITS_AB]));
                exp_c[r][c] = BITS_C'(s);
            end
        exp_q.delete();
        for (int i = 0; i < NW; i++)
            exp_q.push_back('{1'b1, (i < DIM ? 16'h100 : 16'h200) | 16'((i % DIM) << 3), words[i], 0});
        if (j.clr)
            for (int i = 0; i < NW; i++) exp_q.push_back('{1'b1, 16'h300 | 16'(i << 3), 64'(0), 0});
        si = exp_q.size();
        exp_q.push_back('{1'b1, 16'h400, 64'(0), 0});
        for (int i = 0; i < NW; i++) exp_q.push_back('{1'b0, 16'h300 | 16'(i << 3), 64'(0), 0});
        mon_q.delete();
        out_q.delete();
        done_cnt   = 0;
        rprob_g    = j.rprob;
        stall_at   = j.stall ? 3 : -1;
        stall_left = j.stall ? 5 : 0;
        pulse_start(j.clr);
        fork
            feed(NW, j.vprob);
            if (j.spur) spurious();
        join
        while (done_cnt == 0 && g < 3000) begin @(negedge clk); g++; end
        repeat (6) @(negedge clk);
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("busy_after_done", 64'(busy), 64'(0));
        check("txn_count", 64'(mon_q.size()), 64'(j.exp_txn));
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            check($sformatf("txn%0d_rw_addr", i), 64'({mon_q[i].rw, mon_q[i].addr}), 64'({exp_q[i].rw, exp_q[i].addr}));
            check($sformatf("txn%0d_wdata", i), mon_q[i].data, exp_q[i].data);
        end
        if (mon_q.size() > si + 1)
            check("wait_gap", 64'(mon_q[si+1].cyc - mon_q[si].cyc - 1), 64'(WAIT_CYC));
        if (j.rprob == 100 && !j.stall && mon_q.size() == exp_q.size())
            check("read_rate", 64'(mon_q[mon_q.size()-1].cyc - mon_q[si+1].cyc), 64'(NW-1));
        if (j.stall)
            check("stall_applied", 64'(stall_left), 64'(0));
        check("out_count", 64'(out_q.size()), 64'(NW));
        for (int i = 0; i < NW && i < out_q.size(); i++)
            check($sformatf("out_word%0d", i), out_q[i], exp_word(i));
        stall_at = -1;
    endtask

    initial begin
        tbl[0] = '{clr: 1'b0, pat: 0, vprob: 100, rprob: 100, spur: 1'b0, stall: 1'b0, exp_txn: 33};
        tbl[1] = '{clr: 1'b1, pat: 1, vprob: 100, rprob: 100, spur: 1'b0, stall: 1'b0, exp_txn: 49};
        tbl[2] = '{clr: 1'b0, pat: 1, vprob: 50,  rprob: 100, spur: 1'b0, stall: 1'b0, exp_txn: 33};
        tbl[3] = '{clr: 1'b1, pat: 1, vprob: 50,  rprob: 60,  spur: 1'b1, stall: 1'b0, exp_txn: 49};
        tbl[4] = '{clr: 1'b0, pat: 1, vprob: 30,  rprob: 30,  spur: 1'b0, stall: 1'b0, exp_txn: 33};
        tbl[5] = '{clr: 1'b1, pat: 1, vprob: 100, rprob: 100, spur: 1'b1, stall: 1'b0, exp_txn: 49};
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        foreach (tbl[t])
            run_job(tbl[t]);
        run_job('{clr: 1'b1, pat: 1, vprob: 100, rprob: 100, spur: 1'b0, stall: 1'b1, exp_txn: 49});
        // abandon a job three rows into B, with a B write still on the bus
        make_words(1);
        pulse_start(1'b0);
        feed(DIM+3, 100);
        check("abort_write_on_bus", 64'(bus.tpu_r_w), 64'(1));
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midjob_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_job('{clr: 1'b1, pat: 1, vprob: 70, rprob: 80, spur: 1'b0, stall: 1'b0, exp_txn: 49});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
